// File: rtl/prog_load_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prog_load_ctrl
// Purpose  : Loads a program image received over a UART byte stream into
//            program memory, then grants the fetch stage permission to run.
//            Frame: 4-byte little-endian word count N, then N little-endian
//            32-bit words. Written to consecutive word addresses from 0.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            rx_valid, rx_data - received byte strobe and data
//            fetch_addr        - fetch stage byte address (passed to memory
//                                whenever no write is in progress)
//            run_finished      - end-of-program pulse from fetch (RUN only)
//            mem_we/mem_addr/mem_wdata - program memory write port
//            run_flag          - fetch/PC advance permitted
//            load_done         - pulse alongside the final word write
//            load_error        - sticky: bad header length or byte timeout
//            word_count        - words written in the current frame
// Revision : 1.0 - initial release
// ============================================================================
module prog_load_ctrl #(
  parameter int MEM_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [31:0] fetch_addr,
  input  logic        run_finished,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        run_flag,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] word_count
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_shift;      // little-endian byte assembler
  logic [1:0]         r_byte_cnt;
  logic [15:0]        r_n;          // frame length in words
  logic [GAP_W-1:0]   r_gap;
  logic [31:0]        r_wr_addr;
  logic               r_mem_we;
  logic               r_load_done;
  logic [31:0]        r_mem_wdata;
  logic [15:0]        r_word_count;

  logic               w_in_frame;
  logic [31:0]        w_full;
  logic               w_timeout;
  logic               w_hdr_done;
  logic               w_hdr_bad;
  logic               w_load_accept;
  logic               w_word_done;

  // Bytes arrive LSB first, so shifting in from the top leaves byte k at
  // bits [8k+7:8k] once four bytes have been taken.
  assign w_full        = {rx_data, r_shift[31:8]};
  assign w_in_frame    = (r_state == S_HDR) || (r_state == S_LOAD);
  assign w_timeout     = w_in_frame && !rx_valid &&
                         (r_gap == GAP_W'(TIMEOUT_CYCLES - 1));
  assign w_hdr_done    = (r_state == S_HDR) && rx_valid && (r_byte_cnt == 2'd3);
  assign w_hdr_bad     = (w_full == 32'd0) || (w_full > 32'(MEM_WORDS));
  // Once N words are in, trailing bytes are dropped so word_count never passes N.
  assign w_load_accept = (r_state == S_LOAD) && rx_valid && (r_word_count != r_n);
  assign w_word_done   = w_load_accept && (r_byte_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (rx_valid) w_state_next = S_HDR;
      S_HDR: begin
        if (w_timeout)       w_state_next = S_ERR;
        else if (w_hdr_done) w_state_next = w_hdr_bad ? S_ERR : S_LOAD;
      end
      S_LOAD: begin
        if (w_timeout)        w_state_next = S_ERR;
        else if (r_load_done) w_state_next = S_RUN;
      end
      S_RUN:  if (run_finished) w_state_next = S_IDLE;
      S_ERR:  w_state_next = S_ERR;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift      <= '0;
      r_byte_cnt   <= '0;
      r_n          <= '0;
      r_gap        <= '0;
      r_wr_addr    <= '0;
      r_mem_we     <= 1'b0;
      r_load_done  <= 1'b0;
      r_mem_wdata  <= '0;
      r_word_count <= '0;
    end else begin
      r_mem_we    <= 1'b0;
      r_load_done <= 1'b0;

      if (!w_in_frame || rx_valid) r_gap <= '0;
      else                         r_gap <= r_gap + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_shift    <= w_full;
            r_byte_cnt <= 2'd1;
          end
        end
        S_HDR: begin
          if (rx_valid) begin
            r_shift    <= w_full;
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
          if (w_hdr_done && !w_hdr_bad) begin
            r_n          <= w_full[15:0];
            r_word_count <= '0;
          end
        end
        S_LOAD: begin
          if (w_load_accept) begin
            r_shift    <= w_full;
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
          // Write is issued the cycle after the 4th byte; the count steps
          // together with it, so the address uses the pre-increment value.
          if (w_word_done) begin
            r_mem_we     <= 1'b1;
            r_mem_wdata  <= w_full;
            r_wr_addr    <= {14'd0, r_word_count, 2'b00};
            r_word_count <= r_word_count + 16'd1;
            r_load_done  <= ((r_word_count + 16'd1) == r_n);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_we ? r_wr_addr : fetch_addr;
  assign mem_wdata  = r_mem_wdata;
  assign run_flag   = (r_state == S_RUN);
  assign load_done  = r_load_done;
  assign load_error = (r_state == S_ERR);
  assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_prog_load_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_prog_load_ctrl
// Purpose  : Self-checking bench for prog_load_ctrl. A cycle table covers a
//            two-word load, run/finish and a reload; hand sequences cover
//            back-to-back bytes, bad headers, byte timeout and reset mid-load.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_load_ctrl;

  localparam int MW = 16;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] fetch_addr = 32'h0;
  logic        run_finished = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        run_flag;
  logic        load_done;
  logic        load_error;
  logic [15:0] word_count;

  always #5 clk = ~clk;

  prog_load_ctrl #(.MEM_WORDS(MW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .fetch_addr(fetch_addr), .run_finished(run_finished),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .run_flag(run_flag), .load_done(load_done), .load_error(load_error),
    .word_count(word_count)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  d;
    logic        rf;
    logic [31:0] fa;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        run;
    logic        done;
    logic        err;
    logic [15:0] wc;
  } vec_t;

  vec_t tbl[$];

  // Expected mem_addr is the driven fetch_addr whenever no write is expected.
  task automatic add(input logic rst, input logic v, input logic [7:0] d, input logic rf,
                     input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic run, input logic done, input logic err,
                     input logic [15:0] wc);
    vec_t e;
    e.rst = rst; e.v = v; e.d = d; e.rf = rf;
    e.fa = 32'h1000 + 32'(tbl.size()) * 4;
    e.we = we; e.addr = we ? addr : e.fa; e.wd = wd;
    e.run = run; e.done = done; e.err = err; e.wc = wc;
    tbl.push_back(e);
  endtask

  function automatic logic [95:0] outs();
    return {12'd0, mem_we, mem_addr, mem_wdata, run_flag, load_done, load_error, word_count};
  endfunction

  // Write log for hand-written sequences
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          done_cnt;
  int          done_idx;
  int          stray_done;
  logic        prev_we;
  logic        dbl;

  task automatic clear_log();
    wa_q.delete(); wd_q.delete();
    done_cnt = 0; done_idx = -1; stray_done = 0; prev_we = 1'b0; dbl = 1'b0;
  endtask

  task automatic tick(input logic v, input logic [7:0] d, input logic rf, input logic rst);
    @(negedge clk);
    rx_valid = v; rx_data = d; run_finished = rf; reset = rst;
    fetch_addr = $urandom;
    @(posedge clk);
    #1;
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      if (load_done) begin
        done_cnt++;
        done_idx = wa_q.size() - 1;
      end
      if (prev_we) dbl = 1'b1;
    end else begin
      if (load_done) stray_done++;
      chk("addr_passthru", {64'd0, mem_addr}, {64'd0, fetch_addr});
    end
    prev_we = mem_we;
  endtask

  task automatic send4(input logic [31:0] w);
    tick(1'b1, w[7:0],   1'b0, 1'b0);
    tick(1'b1, w[15:8],  1'b0, 1'b0);
    tick(1'b1, w[23:16], 1'b0, 1'b0);
    tick(1'b1, w[31:24], 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  logic early;

  initial begin
    // ---------------- cycle table: rst v d rf | we addr wd run done err wc
    add(1,0,8'h00,0, 0,0,32'h0,        0,0,0,0);  // reset state
    add(0,1,8'h02,0, 0,0,32'h0,        0,0,0,0);  // header N=2
    add(0,1,8'h00,0, 0,0,32'h0,        0,0,0,0);
    add(0,1,8'h00,0, 0,0,32'h0,        0,0,0,0);
    add(0,1,8'h00,0, 0,0,32'h0,        0,0,0,0);
    add(0,1,8'h13,0, 0,0,32'h0,        0,0,0,0);  // word 0
    add(0,1,8'h00,0, 0,0,32'h0,        0,0,0,0);
    add(0,1,8'h00,0, 0,0,32'h0,        0,0,0,0);
    add(0,1,8'h00,0, 1,0,32'h00000013, 0,0,0,1);  // write @0
    add(0,1,8'h93,0, 0,0,32'h00000013, 0,0,0,1);  // word 1, wdata holds
    add(0,1,8'h00,0, 0,0,32'h00000013, 0,0,0,1);
    add(0,1,8'h10,0, 0,0,32'h00000013, 0,0,0,1);
    add(0,1,8'h00,0, 1,4,32'h00100093, 0,1,0,2);  // write @4 + load_done
    add(0,0,8'h00,0, 0,0,32'h00100093, 1,0,0,2);  // RUN
    add(0,1,8'hFF,0, 0,0,32'h00100093, 1,0,0,2);  // rx ignored in RUN
    add(0,0,8'h00,1, 0,0,32'h00100093, 0,0,0,2);  // run_finished -> IDLE
    add(0,0,8'h00,1, 0,0,32'h00100093, 0,0,0,2);  // run_finished in IDLE: no effect
    add(0,1,8'h01,0, 0,0,32'h00100093, 0,0,0,2);  // header N=1
    add(0,1,8'h00,0, 0,0,32'h00100093, 0,0,0,2);
    add(0,1,8'h00,0, 0,0,32'h00100093, 0,0,0,2);
    add(0,1,8'h00,0, 0,0,32'h00100093, 0,0,0,0);  // LOAD, count cleared
    add(0,1,8'hAA,0, 0,0,32'h00100093, 0,0,0,0);
    add(0,1,8'hBB,0, 0,0,32'h00100093, 0,0,0,0);
    add(0,1,8'hCC,0, 0,0,32'h00100093, 0,0,0,0);
    add(0,1,8'hDD,0, 1,0,32'hDDCCBBAA, 0,1,0,1);  // single word @0, done
    add(0,0,8'h00,0, 0,0,32'hDDCCBBAA, 1,0,0,1);  // RUN
    add(1,0,8'h00,0, 0,0,32'h0,        0,0,0,0);  // reset from RUN

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst; rx_valid = tbl[i].v; rx_data = tbl[i].d;
      run_finished = tbl[i].rf; fetch_addr = tbl[i].fa;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), outs(),
          {12'd0, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].run, tbl[i].done,
           tbl[i].err, tbl[i].wc});
    end

    // ---------------- back-to-back bytes, N=3
    clear_log();
    tick(0, 8'h00, 0, 1);
    send4(32'd3);
    send4(32'h04030201);
    send4(32'h08070605);
    send4(32'h0C0B0A09);
    idle(1);
    chk("b2b_nwrites", 96'(wa_q.size()), 96'd3);
    chk("b2b_addr0", {64'd0, wa_q[0]}, 96'h0);
    chk("b2b_addr1", {64'd0, wa_q[1]}, 96'h4);
    chk("b2b_addr2", {64'd0, wa_q[2]}, 96'h8);
    chk("b2b_data0", {64'd0, wd_q[0]}, 96'h04030201);
    chk("b2b_data1", {64'd0, wd_q[1]}, 96'h08070605);
    chk("b2b_data2", {64'd0, wd_q[2]}, 96'h0C0B0A09);
    chk("b2b_we_single", {95'd0, dbl}, 96'd0);
    chk("b2b_done_cnt", 96'(done_cnt), 96'd1);
    chk("b2b_done_idx", 96'(done_idx), 96'd2);
    chk("b2b_stray_done", 96'(stray_done), 96'd0);
    chk("b2b_run", {95'd0, run_flag}, 96'd1);
    chk("b2b_wc", {80'd0, word_count}, 96'd3);

    // ---------------- bad headers: N=0, N=MW+1; boundary N=MW accepted
    clear_log();
    tick(0, 8'h00, 0, 1);
    send4(32'd0);
    chk("n0_err", {95'd0, load_error}, 96'd1);
    send4(32'h11223344);
    chk("n0_err_sticky", {95'd0, load_error}, 96'd1);
    chk("n0_run", {95'd0, run_flag}, 96'd0);
    tick(0, 8'h00, 0, 1);
    send4(32'(MW + 1));
    chk("nbig_err", {95'd0, load_error}, 96'd1);
    send4(32'h55667788);
    chk("nbig_run", {95'd0, run_flag}, 96'd0);
    chk("bad_hdr_nwrites", 96'(wa_q.size()), 96'd0);
    tick(0, 8'h00, 0, 1);
    send4(32'(MW));
    chk("nmax_no_err", {95'd0, load_error}, 96'd0);

    // ---------------- byte timeout after 2 bytes of word 0
    clear_log();
    tick(0, 8'h00, 0, 1);
    send4(32'd1);
    tick(1, 8'hAA, 0, 0);
    tick(1, 8'hBB, 0, 0);
    early = 1'b0;
    for (int k = 1; k <= TO - 1; k++) begin
      tick(0, 8'h00, 0, 0);
      if (load_error) early = 1'b1;
    end
    chk("timeout_not_early", {95'd0, early}, 96'd0);
    tick(0, 8'h00, 0, 0);
    chk("timeout_at_16", {95'd0, load_error}, 96'd1);
    send4(32'hDDCC0000);
    send4(32'h12345678);
    chk("timeout_nwrites", 96'(wa_q.size()), 96'd0);
    chk("timeout_err_sticky", {95'd0, load_error}, 96'd1);
    chk("timeout_run", {95'd0, run_flag}, 96'd0);

    // ---------------- reset mid-load of a 4-word frame
    clear_log();
    tick(0, 8'h00, 0, 1);
    send4(32'd4);
    send4(32'hCAFE0001);
    tick(1, 8'h11, 0, 0);
    tick(1, 8'h22, 0, 0);
    tick(1, 8'h33, 0, 0);
    tick(1, 8'h44, 0, 1);   // last byte of word 1 coincides with reset
    chk("rst_outputs", outs(), {12'd0, 1'b0, fetch_addr, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0});
    idle(2);
    chk("rst_nwrites", 96'(wa_q.size()), 96'd1);
    chk("rst_first_addr", {64'd0, wa_q[0]}, 96'h0);
    clear_log();
    send4(32'd2);
    send4(32'h00000013);
    send4(32'h00100093);
    idle(1);
    chk("reload_nwrites", 96'(wa_q.size()), 96'd2);
    chk("reload_addr0", {64'd0, wa_q[0]}, 96'h0);
    chk("reload_data0", {64'd0, wd_q[0]}, 96'h00000013);
    chk("reload_addr1", {64'd0, wa_q[1]}, 96'h4);
    chk("reload_data1", {64'd0, wd_q[1]}, 96'h00100093);
    chk("reload_run", {95'd0, run_flag}, 96'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_load_ctrl.md
PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

Interface
REQ-001 Parameter MEM_WORDS, default 1024: program memory capacity in 32-bit words.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum idle gap between bytes inside a frame.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_valid  input  1  one-cycle strobe from the UART byte receiver.
REQ-006 rx_data  input  8  received byte; valid only when rx_valid=1.
REQ-007 fetch_addr  input  32  byte address requested by the fetch stage.
REQ-008 run_finished  input  1  pulse from fetch signalling program end.
REQ-009 mem_we  output  1  program memory write enable.
REQ-010 mem_addr  output  32  program memory byte address.
REQ-011 mem_wdata  output  32  program memory write data.
REQ-012 run_flag  output  1  permits fetch/PC advance.
REQ-013 load_done  output  1  one-cycle pulse when the last word has been written.
REQ-014 load_error  output  1  sticky error flag.
REQ-015 word_count  output  16  number of words written in the current frame.

Function
REQ-016 The block SHALL implement the FSM states IDLE, HDR, LOAD, RUN and ERR.
REQ-017 Frame format SHALL be: 4-byte little-endian header N (word count), then N words, each sent as 4 bytes little-endian.
REQ-018 IDLE: the first rx_valid SHALL capture byte 0 of the header and move the FSM to HDR.
REQ-019 HDR: header bytes 1..3 SHALL be accumulated; on the 4th byte, N=0 or N>MEM_WORDS SHALL go to ERR, otherwise the FSM SHALL go to LOAD with word_count=0.
REQ-020 LOAD: bytes SHALL be assembled into a word with byte k at bits [8k+7:8k], k=0..3.
REQ-021 On the 4th byte of a word, the next cycle SHALL have mem_we=1 for exactly one cycle, with mem_addr=word_count*4 and mem_wdata equal to the assembled word; word_count SHALL increment in that same cycle.
REQ-022 When the written word is word N-1, load_done SHALL pulse in the same cycle as that mem_we, and the FSM SHALL enter RUN on the following edge.
REQ-023 RUN: run_flag SHALL be 1.
REQ-024 RUN: rx_valid SHALL be ignored.
REQ-025 RUN: run_finished=1 SHALL clear run_flag on the next edge and return the FSM to IDLE; word_count SHALL hold its value.
REQ-026 Arbitration: mem_addr SHALL equal the load address when mem_we=1, otherwise fetch_addr (combinational pass-through).
REQ-027 run_flag SHALL be 0 in IDLE, HDR, LOAD and ERR, so fetch never contends with a write.
REQ-028 Timeout: a gap counter SHALL clear on each rx_valid and count cycles while in HDR or LOAD.
REQ-029 When the gap counter reaches TIMEOUT_CYCLES, the FSM SHALL enter ERR.
REQ-030 The gap counter SHALL be idle in IDLE and RUN.
REQ-031 ERR: load_error=1, run_flag=0, mem_we=0; all rx_valid SHALL be ignored; only reset exits ERR.
REQ-032 If rx_valid arrives in the same cycle as a pending mem_we, the byte SHALL be captured without loss.
REQ-033 run_finished outside RUN SHALL have no effect.
REQ-034 The byte-within-word counter SHALL wrap 3->0; word_count SHALL never exceed N.
REQ-035 mem_wdata SHALL hold its last value when mem_we=0.

Reset
REQ-036 reset=1 at any edge SHALL force: state IDLE, mem_we=0, run_flag=0, load_done=0, load_error=0, word_count=0, mem_wdata=0, gap and byte counters =0.
REQ-037 Reset asserted mid-LOAD or mid-RUN SHALL abort immediately with no further writes; the partial frame is discarded.

Verification
REQ-038 Header 02 00 00 00, then bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013 @0x0 and 0x00100093 @0x4; load_done pulses with the 2nd write; run_flag=1 next cycle.
REQ-039 In RUN, pulse run_finished -> run_flag=0 next cycle, state IDLE, word_count=2; a new 1-word frame then loads to @0x0.
REQ-040 Header N=0, and separately N=MEM_WORDS+1 -> load_error=1 after the 4th header byte, no mem_we, run_flag stays 0.
REQ-041 TIMEOUT_CYCLES=16; stop after 2 bytes of word 0 -> load_error=1 exactly 16 cycles after the last rx_valid; later bytes are ignored.
REQ-042 Back-to-back rx_valid every cycle for N=3 -> 3 single-cycle mem_we pulses at addresses 0/4/8 with correct data; when mem_we=0, mem_addr tracks fetch_addr.
REQ-043 reset asserted after word 1 of a 4-word frame -> all outputs at reset values next cycle; a fresh frame then loads correctly from @0x0.
